// File: rtl/write_mem_ctrl_if.sv
// rtl/write_mem_ctrl_if.sv - burst write, stream and read-back signals of write_mem_ctrl
interface write_mem_ctrl_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 4
);
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W:0]   burst_len;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              busy;
   logic              done;
   logic [ADDR_W:0]   wr_count;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;

   modport master (
      output start, base_addr, burst_len, in_valid, in_data, rd_addr,
      input  in_ready, busy, done, wr_count, rd_data
   );

   modport slave (
      input  start, base_addr, burst_len, in_valid, in_data, rd_addr,
      output in_ready, busy, done, wr_count, rd_data
   );
endinterface

// File: rtl/write_mem_ctrl.sv
// rtl/write_mem_ctrl.sv - 64x4 memory with burst write engine and registered read port
// Optional macro WRITE_MEM_RD_BYPASS_EN: same-address read during a write returns the new data.
module write_mem_ctrl #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 4,
   parameter int DEPTH  = 64
) (
   input  logic            clk,
   input  logic            rst,
   write_mem_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(DEPTH);

   state_t            state, next_state;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W:0]   remaining;
   logic [ADDR_W:0]   wr_count;
   logic [ADDR_W:0]   len_clamped;
   logic              wr_en;
   logic              start_ok;

   assign len_clamped = (bus.burst_len > MAX_LEN) ? MAX_LEN : bus.burst_len;
   assign wr_en       = (state == BURST) && bus.in_valid;
   assign start_ok    = (state == IDLE) && bus.start;
   assign bus.wr_count = wr_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state   = state;
      bus.in_ready = 1'b0;
      bus.busy     = 1'b0;
      bus.done     = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               next_state = (len_clamped == '0) ? DONE : BURST;
            end
         end
         BURST: begin
            bus.in_ready = 1'b1;
            bus.busy     = 1'b1;
            if (bus.in_valid && remaining == (ADDR_W+1)'(1)) begin
               next_state = DONE;
            end
         end
         DONE: begin
            bus.busy   = 1'b1;
            bus.done   = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr    <= '0;
         remaining <= '0;
         wr_count  <= '0;
      end else if (start_ok) begin
         wr_ptr    <= bus.base_addr;
         remaining <= len_clamped;
         wr_count  <= '0;
      end else if (wr_en) begin
         wr_ptr    <= wr_ptr + 1'b1;
         remaining <= remaining - 1'b1;
         wr_count  <= wr_count + 1'b1;
      end
   end

   // Whole array clears on reset so read-back after an aborted burst is deterministic.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[wr_ptr] <= bus.in_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.rd_data <= '0;
      end else begin
`ifdef WRITE_MEM_RD_BYPASS_EN
         if (wr_en && bus.rd_addr == wr_ptr) begin
            bus.rd_data <= bus.in_data;
         end else begin
            bus.rd_data <= mem[bus.rd_addr];
         end
`else
         bus.rd_data <= mem[bus.rd_addr];
`endif
      end
   end
endmodule

// File: tb/tb_write_mem_ctrl.sv
// tb/tb_write_mem_ctrl.sv - directed self-checking bench for write_mem_ctrl
module tb_write_mem_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;
   int   done_cnt;

   write_mem_ctrl_if #(.ADDR_W(6), .DATA_W(4)) bus ();

   write_mem_ctrl #(.ADDR_W(6), .DATA_W(4), .DEPTH(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd_chk(input int addr, input logic [3:0] exp);
      bus.rd_addr = 6'(addr);
      tick();
      chk($sformatf("rd[%0d]", addr), 32'(bus.rd_data), 32'(exp));
   endtask

   task automatic start_burst(input int base, input int len);
      bus.start     = 1'b1;
      bus.base_addr = 6'(base);
      bus.burst_len = 7'(len);
      tick();
      bus.start     = 1'b0;
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.base_addr = '0;
      bus.burst_len = '0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.rd_addr   = '0;

      // reset asserted off the clock edge
      #3 rst = 1'b0;
      #20;
      chk("rst_in_ready", 32'(bus.in_ready), 0);
      chk("rst_busy",     32'(bus.busy),     0);
      chk("rst_done",     32'(bus.done),     0);
      chk("rst_wr_count", 32'(bus.wr_count), 0);
      chk("rst_rd_data",  32'(bus.rd_data),  0);
      tick();
      rst = 1'b1;
      for (int a = 0; a < 64; a++) rd_chk(a, 4'h0);

      // base 10, length 3, valid held high
      start_burst(10, 3);
      chk("b1_in_ready", 32'(bus.in_ready), 1);
      chk("b1_busy",     32'(bus.busy),     1);
      bus.in_valid = 1'b1; bus.in_data = 4'hA; tick();
      bus.in_data = 4'hB; tick();
      bus.in_data = 4'hC; tick();
      bus.in_valid = 1'b0;
      chk("b1_done",     32'(bus.done),     1);
      chk("b1_in_ready_done", 32'(bus.in_ready), 0);
      chk("b1_wr_count", 32'(bus.wr_count), 3);
      tick();
      chk("b1_done_low", 32'(bus.done),     0);
      chk("b1_idle",     32'(bus.busy),     0);
      chk("b1_count_hold", 32'(bus.wr_count), 3);
      rd_chk(10, 4'hA);
      rd_chk(11, 4'hB);
      rd_chk(12, 4'hC);
      rd_chk(13, 4'h0);

      // wrap-around with in_valid toggling
      start_burst(62, 4);
      done_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         bus.in_valid = (i % 2 == 0);
         bus.in_data  = 4'(i / 2 + 1);
         tick();
         if (bus.done) done_cnt++;
         if (i == 1) chk("wrap_stall_count", 32'(bus.wr_count), 1);
      end
      bus.in_valid = 1'b0;
      chk("wrap_done_once", 32'(done_cnt), 1);
      chk("wrap_wr_count", 32'(bus.wr_count), 4);
      rd_chk(62, 4'h1);
      rd_chk(63, 4'h2);
      rd_chk(0,  4'h3);
      rd_chk(1,  4'h4);
      rd_chk(2,  4'h0);

      // zero-length burst
      start_burst(20, 0);
      chk("z_done",     32'(bus.done),     1);
      chk("z_busy",     32'(bus.busy),     1);
      chk("z_wr_count", 32'(bus.wr_count), 0);
      tick();
      chk("z_idle", 32'(bus.busy), 0);
      rd_chk(20, 4'h0);

      // start held during BURST and DONE must be ignored
      start_burst(30, 2);
      bus.start = 1'b1; bus.base_addr = 6'd40; bus.burst_len = 7'd1;
      bus.in_valid = 1'b1; bus.in_data = 4'h7; tick();
      bus.in_data = 4'h8; tick();
      bus.in_valid = 1'b0;
      chk("ign_done",  32'(bus.done),     1);
      chk("ign_count", 32'(bus.wr_count), 2);
      tick();
      bus.start = 1'b0;
      chk("ign_idle", 32'(bus.busy), 0);
      tick();
      chk("ign_still_idle", 32'(bus.busy), 0);
      rd_chk(30, 4'h7);
      rd_chk(31, 4'h8);
      rd_chk(40, 4'h0);

      // oversize length clamps to 64: every word overwritten once
      start_burst(5, 127);
      for (int i = 0; i < 64; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 4'(i + 3);
         tick();
      end
      bus.in_valid = 1'b0;
      chk("full_done",  32'(bus.done),     1);
      chk("full_count", 32'(bus.wr_count), 64);
      tick();
      chk("full_idle", 32'(bus.busy), 0);
      for (int a = 0; a < 64; a++) rd_chk(a, 4'(((a - 5 + 64) % 64) + 3));

      // reset after 2 of 5 words
      start_burst(0, 5);
      bus.in_valid = 1'b1; bus.in_data = 4'h9; tick();
      bus.in_data = 4'h6; tick();
      bus.in_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_busy",     32'(bus.busy),     0);
      chk("mid_rst_in_ready", 32'(bus.in_ready), 0);
      chk("mid_rst_rd_data",  32'(bus.rd_data),  0);
      tick();
      rst = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (bus.done) done_cnt++;
      end
      chk("mid_no_done",  32'(done_cnt),     0);
      chk("mid_idle",     32'(bus.busy),     0);
      chk("mid_wr_count", 32'(bus.wr_count), 0);
      for (int a = 0; a < 64; a++) rd_chk(a, 4'h0);

      // same-cycle read and write to address 7
      start_burst(7, 1);
      bus.rd_addr  = 6'd7;
      bus.in_valid = 1'b1;
      bus.in_data  = 4'h5;
      tick();
      bus.in_valid = 1'b0;
`ifdef WRITE_MEM_RD_BYPASS_EN
      chk("rw_same_cycle", 32'(bus.rd_data), 5);
`else
      chk("rw_same_cycle", 32'(bus.rd_data), 0);
`endif
      chk("rw_done", 32'(bus.done), 1);
      tick();
      chk("rw_next_cycle", 32'(bus.rd_data), 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
